// File: rtl/wisc_pipe_pkg.sv
// rtl/wisc_pipe_pkg.sv - shared types and constants for the WISC hazard controller
package wisc_pipe_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } hz_state_e;

  // rd is stored at a fixed width so the entry type does not depend on REG_ADDR_W
  localparam int SB_RD_W = 8;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               reg_write;
    logic               is_load;
  } sb_entry_t;

  localparam logic [SB_RD_W-1:0] REG_ZERO = '0;

  localparam sb_entry_t OP_NOP = '{valid: 1'b0, rd: REG_ZERO, reg_write: 1'b0, is_load: 1'b0};

  function automatic logic sb_match(input sb_entry_t e, input logic [SB_RD_W-1:0] src,
                                    input logic used);
    return e.valid && e.reg_write && used && (src != REG_ZERO) && (e.rd == src);
  endfunction

endpackage

// File: rtl/wisc_sb_chain.sv
// rtl/wisc_sb_chain.sv - destination scoreboard shift chain, entry 0 = EX stage
module wisc_sb_chain
  import wisc_pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  bubble,
  input  logic                  flush,
  input  sb_entry_t             in_entry,
  output sb_entry_t [DEPTH-1:0] entries
);

  sb_entry_t [DEPTH-1:0] chain_q;
  sb_entry_t [DEPTH-1:0] chain_d;

  always_comb begin
    chain_d = chain_q;
    if (!hold) begin
      chain_d[0] = (bubble || flush) ? OP_NOP : in_entry;
      for (int i = 1; i < DEPTH; i++) begin
        chain_d[i] = chain_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        chain_q[i] <= OP_NOP;
      end
    end else begin
      chain_q <= chain_d;
    end
  end

  assign entries = chain_q;

endmodule

// File: rtl/wisc_hazard_ctrl.sv
// rtl/wisc_hazard_ctrl.sv - WISC stall/flush/forward controller
// Forwarding mode is selected by defining WISC_FORWARDING_EN; otherwise RAW hazards stall.
module wisc_hazard_ctrl
  import wisc_pipe_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int REG_ADDR_W = 4,
  parameter int FWD_DIST   = NUM_STAGES - 3,
  parameter int FWD_W      = $clog2(FWD_DIST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  ex_br_taken,
  input  logic                  mem_busy,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  bubble_idex,
  output logic                  flush_ifid,
  output logic                  freeze_mem,
  output logic [FWD_W-1:0]      fwd_sel_a,
  output logic [FWD_W-1:0]      fwd_sel_b,
  output logic [15:0]           stall_cnt
);

  hz_state_e state_q, state_d;
  logic br_pending_q, br_pending_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  sb_entry_t [FWD_DIST-1:0] sb;
  sb_entry_t id_entry;
  logic [SB_RD_W-1:0] rs_ext, rt_ext;
  logic chk_en;
  logic [FWD_W-1:0] sel_a, sel_b;
  logic load_use, hazard;

  assign rs_ext = SB_RD_W'(id_rs);
  assign rt_ext = SB_RD_W'(id_rt);

  assign id_entry = '{valid: id_valid, rd: SB_RD_W'(id_rd), reg_write: id_reg_write,
                      is_load: id_is_load};

  wisc_sb_chain #(.DEPTH(FWD_DIST)) u_sb_chain (
    .clk     (clk),
    .rst     (rst),
    .hold    (freeze_mem),
    .bubble  (bubble_idex),
    .flush   (flush_ifid),
    .in_entry(id_entry),
    .entries (sb)
  );

  // ID is empty right after a flush, so nothing there can create a hazard
  assign chk_en = id_valid && (state_q != FLUSH);

  // Walk oldest to youngest so the youngest matching producer sets the distance
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = FWD_DIST - 1; k >= 0; k--) begin
      if (chk_en && sb_match(sb[k], rs_ext, id_rs_used)) begin
        sel_a = FWD_W'(k + 1);
      end
      if (chk_en && sb_match(sb[k], rt_ext, id_rt_used)) begin
        sel_b = FWD_W'(k + 1);
      end
    end
  end

  assign load_use = sb[0].is_load && ((sel_a == FWD_W'(1)) || (sel_b == FWD_W'(1)));

`ifdef WISC_FORWARDING_EN
  assign hazard = load_use;
`else
  assign hazard = (sel_a != '0) || (sel_b != '0) || load_use;
`endif

  always_comb begin
    state_d      = state_q;
    br_pending_d = br_pending_q;
    stall_pc     = 1'b0;
    stall_ifid   = 1'b0;
    bubble_idex  = 1'b0;
    flush_ifid   = 1'b0;
    freeze_mem   = 1'b0;
    if (mem_busy) begin
      freeze_mem = 1'b1;
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
      state_d    = MEM_WAIT;
      if (ex_br_taken) begin
        br_pending_d = 1'b1;
      end
    end else if (state_q == FLUSH) begin
      state_d = RUN;
    end else if (ex_br_taken || br_pending_q) begin
      flush_ifid   = 1'b1;
      bubble_idex  = 1'b1;
      br_pending_d = 1'b0;
      state_d      = FLUSH;
    end else if (hazard) begin
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      bubble_idex = 1'b1;
`ifdef WISC_FORWARDING_EN
      state_d     = LOAD_STALL;
`else
      state_d     = RUN;
`endif
    end else begin
      state_d = RUN;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_pc && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RUN;
      br_pending_q <= 1'b0;
      stall_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      br_pending_q <= br_pending_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

`ifdef WISC_FORWARDING_EN
  logic [FWD_W-1:0] fwd_sel_a_q, fwd_sel_a_d, fwd_sel_b_q, fwd_sel_b_d;

  // Captured as the consumer moves ID->EX; frozen with EX, zeroed for bubbles
  always_comb begin
    fwd_sel_a_d = fwd_sel_a_q;
    fwd_sel_b_d = fwd_sel_b_q;
    if (!freeze_mem) begin
      if (bubble_idex || flush_ifid) begin
        fwd_sel_a_d = '0;
        fwd_sel_b_d = '0;
      end else begin
        fwd_sel_a_d = sel_a;
        fwd_sel_b_d = sel_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fwd_sel_a_q <= '0;
      fwd_sel_b_q <= '0;
    end else begin
      fwd_sel_a_q <= fwd_sel_a_d;
      fwd_sel_b_q <= fwd_sel_b_d;
    end
  end

  assign fwd_sel_a = fwd_sel_a_q;
  assign fwd_sel_b = fwd_sel_b_q;
`else
  assign fwd_sel_a = '0;
  assign fwd_sel_b = '0;
`endif

endmodule
